mux_tree_pipe: RTL and testbench

//   Parametrised N:1 multiplexer (N = 2**SEL_W), built as a binary tree of
//   2:1 selections with a register after every tree level.

---
 rtl/mux_tree_pipe.sv | 94 +++++++++
 tb/tb_mux_tree_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer: a binary tree of 2:1 selections, one register
// stage per tree level, with valid/ready flow control on both sides.
module mux_tree_pipe #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic [(2**SEL_W)*WIDTH-1:0]   d,
  input  logic [SEL_W-1:0]              sel,
  output logic                          down_valid,
  input  logic                          down_ready,
  output logic [WIDTH-1:0]              y,
  output logic                          busy
);

  localparam int N  = 2**SEL_W;
  localparam int DW = N*WIDTH;

  logic [SEL_W-1:0] valid_q;
  logic [DW-1:0]    data_q [SEL_W];
  logic [SEL_W-1:0] sel_q  [SEL_W];

  logic [SEL_W-1:0] valid_d;
  logic [DW-1:0]    lvl_data [SEL_W];
  logic [SEL_W-1:0] lvl_sel  [SEL_W];
  logic [DW-1:0]    data_d   [SEL_W];
  logic [SEL_W-1:0] sel_d    [SEL_W];
  logic [SEL_W-1:0] stage_ready;

  always_comb begin
    valid_d     = '0;
    stage_ready = '0;
    for (int k = 0; k < SEL_W; k++) begin
      lvl_data[k] = '0;
      lvl_sel[k]  = '0;
      data_d[k]   = '0;
      sel_d[k]    = '0;
    end

    // Stage k may load unless it and every later stage hold data and the sink stalls.
    for (int k = 0; k < SEL_W; k++) begin
      stage_ready[k] = down_ready ||
                       !(&(valid_q | ~({SEL_W{1'b1}} << k)));
    end

    valid_d[0]  = up_valid;
    lvl_data[0] = d;
    lvl_sel[0]  = sel;
    for (int k = 1; k < SEL_W; k++) begin
      valid_d[k]  = valid_q[k-1];
      lvl_data[k] = data_q[k-1];
      lvl_sel[k]  = sel_q[k-1];
    end

    for (int k = 0; k < SEL_W; k++) begin
      for (int j = 0; j < N/2; j++) begin
        if (j < (N >> (k+1))) begin
          data_d[k][j*WIDTH +: WIDTH] = lvl_sel[k][0] ?
                                        lvl_data[k][(2*j+1)*WIDTH +: WIDTH] :
                                        lvl_data[k][(2*j)*WIDTH +: WIDTH];
        end
      end
      // The select bit just consumed is dropped so bit 0 always steers the next level.
      sel_d[k] = lvl_sel[k] >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < SEL_W; k++) begin
        data_q[k] <= '0;
        sel_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SEL_W; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= valid_d[k];
          data_q[k]  <= data_d[k];
          sel_q[k]   <= sel_d[k];
        end
      end
    end
  end

  assign up_ready   = stage_ready[0] || !rst_n;
  assign down_valid = valid_q[SEL_W-1];
  assign y          = data_q[SEL_W-1][WIDTH-1:0];
  assign busy       = |valid_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: default (4-bit, 4:1), 8-bit 2:1 and 4-bit 8:1 instances.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: WIDTH=4, SEL_W=2
  logic        up_valid, up_ready, down_valid, down_ready, busy;
  logic [15:0] d;
  logic [1:0]  sel;
  logic [3:0]  y;

  // SEL_W=1, WIDTH=8
  logic        a_up_valid, a_up_ready, a_down_valid, a_down_ready, a_busy;
  logic [15:0] a_d;
  logic        a_sel;
  logic [7:0]  a_y;

  // SEL_W=3, WIDTH=4
  logic        b_up_valid, b_up_ready, b_down_valid, b_down_ready, b_busy;
  logic [31:0] b_d;
  logic [2:0]  b_sel;
  logic [3:0]  b_y;

  int n_tests = 0;
  int n_fail  = 0;

  mux_tree_pipe #(.WIDTH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .d(d), .sel(sel), .down_valid(down_valid), .down_ready(down_ready),
    .y(y), .busy(busy));

  mux_tree_pipe #(.WIDTH(8), .SEL_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .up_valid(a_up_valid), .up_ready(a_up_ready),
    .d(a_d), .sel(a_sel), .down_valid(a_down_valid), .down_ready(a_down_ready),
    .y(a_y), .busy(a_busy));

  mux_tree_pipe #(.WIDTH(4), .SEL_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .up_valid(b_up_valid), .up_ready(b_up_ready),
    .d(b_d), .sel(b_sel), .down_valid(b_down_valid), .down_ready(b_down_ready),
    .y(b_y), .busy(b_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    if (got === exp) $display("[TB] %s ok: %0h", tag, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         q[$];
    int         sent;
    int         got;
    logic [3:0] w;
    logic [3:0] item_word [4];

    rst_n = 1'b0;
    up_valid = 1'b0; d = '0; sel = '0; down_ready = 1'b0;
    a_up_valid = 1'b0; a_d = '0; a_sel = 1'b0; a_down_ready = 1'b1;
    b_up_valid = 1'b0; b_d = '0; b_sel = '0; b_down_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // 1. One word per sel value, streamed back to back
    item_word[0] = 4'hA; item_word[1] = 4'hB; item_word[2] = 4'hC; item_word[3] = 4'hD;
    down_ready = 1'b1;
    up_valid   = 1'b1;
    d          = 16'hDCBA;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check("t1_up_ready", 32'(up_ready), 32'd1);
      step();
      if (i >= 1) begin
        check("t1_down_valid", 32'(down_valid), 32'd1);
        check("t1_y", 32'(y), 32'(item_word[i-1]));
      end else begin
        check("t1_latency_dv", 32'(down_valid), 32'd0);
      end
    end
    up_valid = 1'b0;
    step();
    check("t1_down_valid", 32'(down_valid), 32'd1);
    check("t1_y", 32'(y), 32'(item_word[3]));
    step();
    check("t1_drained_dv", 32'(down_valid), 32'd0);
    check("t1_drained_busy", 32'(busy), 32'd0);

    // 2. Unknown on an unselected input
    d        = {4'bxxxx, 4'h3, 4'hA, 4'h7};
    up_valid = 1'b1;
    sel      = 2'd2;
    step();
    sel = 2'd3;
    step();
    up_valid = 1'b0;
    check("t2_y_known", 32'(y), 32'h3);
    step();
    check("t2_sel3_dv", 32'(down_valid), 32'd1);
    step();

    // 3. Backpressure: fill both stages, stall 5 cycles, release
    d          = 16'h4321;
    down_ready = 1'b0;
    up_valid   = 1'b1;
    sel        = 2'd0;
    #1;
    check("t3_up_ready0", 32'(up_ready), 32'd1);
    step();
    sel = 2'd1;
    #1;
    check("t3_up_ready1", 32'(up_ready), 32'd1);
    step();
    sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_full_up_ready", 32'(up_ready), 32'd0);
      step();
      check("t3_stall_dv", 32'(down_valid), 32'd1);
      check("t3_stall_y", 32'(y), 32'h1);
    end
    down_ready = 1'b1;
    #1;
    check("t3_release_up_ready", 32'(up_ready), 32'd1);
    step();
    check("t3_out_item1", 32'(y), 32'h2);
    sel = 2'd3;
    step();
    up_valid = 1'b0;
    check("t3_out_item2", 32'(y), 32'h3);
    step();
    check("t3_out_item3", 32'(y), 32'h4);
    check("t3_out_item3_dv", 32'(down_valid), 32'd1);
    step();
    check("t3_empty_dv", 32'(down_valid), 32'd0);

    // 5. Reset with both stages holding data
    down_ready = 1'b0;
    up_valid   = 1'b1;
    sel        = 2'd0;
    step();
    sel = 2'd1;
    step();
    check("t5_busy_before", 32'(busy), 32'd1);
    check("t5_full_up_ready", 32'(up_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_up_ready", 32'(up_ready), 32'd1);
    step();
    rst_n    = 1'b1;
    up_valid = 1'b0;
    check("t5_post_dv", 32'(down_valid), 32'd0);
    check("t5_post_busy", 32'(busy), 32'd0);
    check("t5_post_y", 32'(y), 32'd0);
    down_ready = 1'b1;
    up_valid   = 1'b1;
    sel        = 2'd3;
    step();
    up_valid = 1'b0;
    check("t5_lat_dv_early", 32'(down_valid), 32'd0);
    step();
    check("t5_lat_dv", 32'(down_valid), 32'd1);
    check("t5_lat_y", 32'(y), 32'h4);
    step();

    // 4. Random valid/ready traffic against a queue of expected words
    sent = 0;
    got  = 0;
    for (int c = 0; c < 300; c++) begin
      up_valid   = (sent < 64) && ($urandom_range(0, 3) != 0);
      d          = 16'($urandom);
      sel        = 2'($urandom_range(0, 3));
      down_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (down_valid && down_ready) begin
        if (q.size() == 0) check("t4_extra_output", 32'd1, 32'd0);
        else check("t4_y", 32'(y), 32'(q.pop_front()));
        got++;
      end
      if (up_valid && up_ready) begin
        w = d[sel*4 +: 4];
        q.push_back(int'(w));
        sent++;
      end
      step();
    end
    up_valid = 1'b0;
    check("t4_items_out", 32'(got), 32'd64);
    check("t4_queue_empty", 32'(q.size()), 32'd0);

    // 6a. SEL_W=1, WIDTH=8
    a_d        = {8'h5A, 8'hA5};
    a_sel      = 1'b1;
    a_up_valid = 1'b1;
    step();
    a_up_valid = 1'b0;
    check("t6a_dv", 32'(a_down_valid), 32'd1);
    check("t6a_y", 32'(a_y), 32'h5A);
    step();
    check("t6a_empty", 32'(a_down_valid), 32'd0);

    // 6b. SEL_W=3: every select value, words equal to their index
    b_d = 32'h7654_3210;
    for (int i = 0; i < 10; i++) begin
      b_up_valid = (i < 8);
      b_sel      = 3'(i);
      step();
      if (i >= 2) begin
        check("t6b_dv", 32'(b_down_valid), 32'd1);
        check("t6b_y", 32'(b_y), 32'(i - 2));
      end else begin
        check("t6b_latency_dv", 32'(b_down_valid), 32'd0);
      end
    end
    b_up_valid = 1'b0;
    step();
    check("t6b_empty", 32'(b_down_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
